aurora_tx_arbiter: RTL and testbench
====================================

AURORA_TX_ARBITER -- requirements
Module: aurora_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, the number of 32-bit AXI-stream requesters (2..8).
REQ-002 SHALL have parameter HEADER_MAGIC, default 16'hCE11, the upper half of the inserted header word.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port auUserClk, input, 1 bit, the Aurora user clock; every register is clocked by it.
REQ-005 SHALL have port auUserReset, input, 1 bit, the asynchronous active-high reset.
REQ-006 SHALL have port linkUp, input, 1 bit, the Aurora channel-up status (already synchronous to auUserClk).
REQ-007 SHALL have port sTdata, input, NUM_PORTS*32 bits, the requester data; port i occupies bits [32i+31:32i].
REQ-008 SHALL have ports sTvalid and sTlast, input, NUM_PORTS bits each, and sTready, output, NUM_PORTS bits.
REQ-009 SHALL have port mTdata, output, 32 bits, and ports mTvalid and mTlast, output, 1 bit each; these feed the link TX stream.
REQ-010 SHALL have port mTready, input, 1 bit, the link TX ready.
REQ-011 SHALL have ports grantValid, output, 1 bit, and grantPort, output, clog2(NUM_PORTS) bits, giving the current owner.
REQ-012 SHALL have port pktCount, output, 32 bits, the number of forwarded packets; it wraps modulo 2^32.

Function
REQ-013 SHALL arbitrate at packet granularity; ownership is held from the grant until the mTlast beat is accepted (mTvalid&&mTready&&mTlast).
REQ-014 SHALL implement the states IDLE, HEADER and DATA.
REQ-015 In IDLE: mTvalid=0, all sTready=0, grantValid=0.
REQ-016 In IDLE with linkUp=1 and any sTvalid set, SHALL pick the first requesting port searching from lastGrant+1 modulo NUM_PORTS, register it as the grant, and move to HEADER (macro on) or DATA (macro off) on the next edge.
REQ-017 The grant decision SHALL cost exactly one cycle, giving exactly one idle cycle between consecutive packets.
REQ-018 In DATA, mTdata, mTvalid and mTlast SHALL equal the granted port's signals combinationally; sTready[g]=mTready; all other sTready=0; zero added latency.
REQ-019 On acceptance of the tlast beat SHALL: increment pktCount, set lastGrant=g, and return to IDLE.
REQ-020 A linkUp deassertion SHALL block only new grants; a packet in progress SHALL complete.
REQ-021 Simultaneous requests SHALL resolve round-robin with no starvation; a lone requester SHALL be regranted back-to-back.
REQ-022 A requester that drops sTvalid mid-packet SHALL keep the grant; mTvalid follows it low.
REQ-023 A single-beat packet (sTlast on the first beat) SHALL be legal and return to IDLE after that beat.

Reset
REQ-024 Asserting auUserReset SHALL immediately force: state=IDLE, lastGrant=NUM_PORTS-1 (so port 0 wins first), pktCount=0, and all of mTvalid, mTlast, sTready, grantValid and grantPort to 0.
REQ-025 A reset mid-packet SHALL abandon the packet with no mTlast emitted; the first post-reset grant follows REQ-016.

Configuration
REQ-026 SHALL use the macro AURORA_TX_ARB_HEADER_EN to compile the header feature in or out.
REQ-027 With AURORA_TX_ARB_HEADER_EN defined, the HEADER state SHALL drive mTvalid=1, mTlast=0 and mTdata={HEADER_MAGIC, 13'b0, grantPort zero-extended to 3 bits}, with all sTready=0, and advance to DATA when mTready=1.
REQ-028 With AURORA_TX_ARB_HEADER_EN undefined, the HEADER state and its logic SHALL be absent and the stream SHALL be passed through unmodified.

Structure
REQ-029 A shared package aurora_arb_pkg SHALL hold the state enum, the default HEADER_MAGIC, and the header field widths and positions.
REQ-030 Round-robin selection SHALL live in one combinational sub-module, rr_priority_pick, with inputs req and lastGrant and outputs anyReq and pick.

Verification
REQ-031 Ports 0..3 each send one 3-beat packet, all requesting at once after reset -> output order 0,1,2,3, one idle cycle between packets, pktCount=4.
REQ-032 Port 2 alone sends three back-to-back packets -> grantPort=2 each time, pktCount=3, no beat lost or duplicated.
REQ-033 mTready toggled 1,0,0,1 during a port-1 packet -> data held stable while stalled, and port-3 requests ignored until the tlast beat is accepted.
REQ-034 linkUp drops mid-packet on port 0 while port 1 is pending -> port 0 completes and port 1 is not granted until linkUp=1.
REQ-035 auUserReset asserted on beat 2 of a 5-beat packet -> mTvalid=0 the same cycle, pktCount=0, and port 0 is granted first after release.
REQ-036 Header macro on, port 3 sends a 2-beat packet -> output is 32'hCE110003 followed by the 2 data beats, with mTlast on the last beat only.

Source files
------------

// File: rtl/aurora_arb_pkg.sv
// aurora_arb_pkg: arbiter state encoding, default header magic and header word layout
package aurora_arb_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, DATA} arb_state_t;
  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hCE11;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_MAGIC_W = 16;
  localparam int HDR_PORT_LSB = 0;
  localparam int HDR_PORT_W = 3;
  function automatic logic [31:0] hdr_word(input logic [HDR_MAGIC_W-1:0] magic, input logic [HDR_PORT_W-1:0] port);
    hdr_word = '0;
    hdr_word[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
    hdr_word[HDR_PORT_LSB +: HDR_PORT_W] = port;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first requester found searching upward from lastGrant+1, wrapping modulo N
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] lastGrant,
  output logic         anyReq,
  output logic [W-1:0] pick
);
  logic [W-1:0] idx;
  always_comb begin
    anyReq = |req;
    pick = '0;
    idx = '0;
    // walk from the farthest offset down so the nearest requester is written last
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(lastGrant) + k) % N);
      pick = req[idx] ? idx : pick;
    end
  end
endmodule

// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter: packet-granular round-robin mux of AXI-stream requesters onto the Aurora TX stream.
// Define AURORA_TX_ARB_HEADER_EN to prefix each packet with a {magic, port} header word.
module aurora_tx_arbiter
  import aurora_arb_pkg::*;
#(
  parameter int          NUM_PORTS    = 4,
  parameter logic [15:0] HEADER_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                         auUserClk,
  input  logic                         auUserReset,
  input  logic                         linkUp,
  input  logic [NUM_PORTS*32-1:0]      sTdata,
  input  logic [NUM_PORTS-1:0]         sTvalid,
  input  logic [NUM_PORTS-1:0]         sTlast,
  output logic [NUM_PORTS-1:0]         sTready,
  output logic [31:0]                  mTdata,
  output logic                         mTvalid,
  output logic                         mTlast,
  input  logic                         mTready,
  output logic                         grantValid,
  output logic [$clog2(NUM_PORTS)-1:0] grantPort,
  output logic [31:0]                  pktCount
);
  localparam int W = $clog2(NUM_PORTS);
  arb_state_t state;
  logic [W-1:0] last_grant, pick;
  logic any_req, in_data;
  logic [31:0] sel_data;
  rr_priority_pick #(.N(NUM_PORTS)) u_pick (
    .req(sTvalid),
    .lastGrant(last_grant),
    .anyReq(any_req),
    .pick(pick)
  );
  always_ff @(posedge auUserClk or posedge auUserReset) begin
    if (auUserReset) begin
      state <= IDLE;
      last_grant <= W'(NUM_PORTS - 1);
      pktCount <= '0;
      grantValid <= 1'b0;
      grantPort <= '0;
    end else begin
      case (state)
        IDLE: if (linkUp && any_req) begin
          grantPort <= pick;
          grantValid <= 1'b1;
`ifdef AURORA_TX_ARB_HEADER_EN
          state <= HEADER;
`else
          state <= DATA;
`endif
        end
`ifdef AURORA_TX_ARB_HEADER_EN
        HEADER: if (mTready) state <= DATA;
`endif
        DATA: if (mTvalid && mTready && mTlast) begin
          pktCount <= pktCount + 32'd1;
          last_grant <= grantPort;
          grantValid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // the data path is a pure combinational mux so DATA adds no latency
  always_comb begin
    in_data = state == DATA;
    sel_data = sTdata[32*grantPort +: 32];
    mTlast = in_data && sTlast[grantPort];
    sTready = (in_data && mTready) ? NUM_PORTS'(1) << grantPort : '0;
`ifdef AURORA_TX_ARB_HEADER_EN
    mTvalid = (state == HEADER) || (in_data && sTvalid[grantPort]);
    mTdata = (state == HEADER) ? hdr_word(HEADER_MAGIC, 3'(grantPort)) : in_data ? sel_data : '0;
`else
    mTvalid = in_data && sTvalid[grantPort];
    mTdata = in_data ? sel_data : '0;
`endif
  end
endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// tb_aurora_tx_arbiter: directed packets per port, scoreboard of expected output beats, checked by a monitor.
// Expectations include the header word when AURORA_TX_ARB_HEADER_EN is defined.
module tb_aurora_tx_arbiter;
  localparam int N = 4;
`ifdef AURORA_TX_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  logic clk = 0, rst = 0, link_up = 1, m_ready = 1;
  logic [N*32-1:0] s_data;
  logic [N-1:0] s_valid, s_last, s_ready, drv_fire;
  logic [31:0] m_data, pkt_count, held;
  logic m_valid, m_last, grant_valid;
  logic [1:0] grant_port;
  typedef struct packed {logic [31:0] d; logic l; logic [1:0] p;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [31:0] bd [N][32];
  logic bl [N][32];
  int wr [N];
  int rd [N];
  int cyc = 0, last_t = -1;
  bit after_t = 1, gap_on = 0, stall = 0;

  always #5 clk = ~clk;

  aurora_tx_arbiter dut (
    .auUserClk(clk), .auUserReset(rst), .linkUp(link_up),
    .sTdata(s_data), .sTvalid(s_valid), .sTlast(s_last), .sTready(s_ready),
    .mTdata(m_data), .mTvalid(m_valid), .mTlast(m_last), .mTready(m_ready),
    .grantValid(grant_valid), .grantPort(grant_port), .pktCount(pkt_count)
  );

  function automatic logic [31:0] mk(int p, int k, int b);
    return {8'(p), 8'(k), 16'hB000 + 16'(b)};
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = rd[i] != wr[i];
      s_last[i] = s_valid[i] && bl[i][rd[i] % 32];
      s_data[i*32 +: 32] = s_valid[i] ? bd[i][rd[i] % 32] : 32'h0;
    end
  endtask

  // queue nb beats on port p; the first nexp of them are expected on the output
  task automatic send(int p, int k, int nb, int nexp);
    if (HDR == 1 && nexp > 0) sb.push_back(exp_t'{d: {16'hCE11, 13'h0, 3'(p)}, l: 1'b0, p: 2'(p)});
    for (int b = 0; b < nb; b++) begin
      bd[p][wr[p] % 32] = mk(p, k, b);
      bl[p][wr[p] % 32] = b == nb - 1;
      wr[p]++;
      if (b < nexp) sb.push_back(exp_t'{d: mk(p, k, b), l: b == nb - 1, p: 2'(p)});
    end
    drive();
  endtask

  // kind 0: grant to port v, 1: data v presented, 2: pktCount==v, 3: scoreboard drained and idle
  task automatic wait_for(string nm, int kind, logic [31:0] v);
    bit ok;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ok = kind == 0 ? (grant_valid && grant_port == v[1:0]) :
           kind == 1 ? (m_valid && m_data == v) :
           kind == 2 ? (pkt_count == v) : (sb.size() == 0 && !grant_valid);
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for %h", nm, v);
  endtask

  // requester model: beats advance on the edge after a sampled handshake
  initial forever begin
    @(negedge clk);
    drv_fire = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (drv_fire[i]) rd[i]++;
    drive();
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (stall) chk("stall_hold", {m_valid, m_data}, {1'b1, held});
    stall = m_valid && !m_ready;
    held = m_data;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got %h want none", m_data);
      end else begin
        e = sb.pop_front();
        chk("beat", {grant_valid, m_last, grant_port, m_data}, {1'b1, e.l, e.p, e.d});
      end
      if (after_t && gap_on && last_t >= 0) chk("idle_gap", 64'(cyc - last_t), 64'd2);
      after_t = m_last;
      if (m_last) last_t = cyc;
    end
  end

  initial begin
    s_valid = 0;
    s_last = 0;
    s_data = 0;
    rst = 1;
    #1;
    chk("reset_out", {m_valid, m_last, s_ready, grant_valid, grant_port}, 0);
    chk("reset_cnt", pkt_count, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    // all four ports request together: 0,1,2,3
    gap_on = 1;
    for (int p = 0; p < N; p++) send(p, 1, 3, 3);
    wait_for("s1_drain", 3, 0);
    chk("s1_count", pkt_count, 4);
    // lone requester regranted back-to-back
    last_t = -1;
    for (int k = 2; k < 5; k++) send(2, k, 3, 3);
    wait_for("s2_drain", 3, 0);
    chk("s2_count", pkt_count, 7);
    gap_on = 0;
    // stalls on port 1 while port 3 waits
    @(posedge clk);
    #2;
    send(1, 5, 3, 3);
    wait_for("s3_grant", 0, 1);
    send(3, 6, 2, 2);
    @(posedge clk);
    #2;
    m_ready = 0;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    m_ready = 1;
    wait_for("s3_drain", 3, 0);
    chk("s3_count", pkt_count, 9);
    // link drop mid-packet on port 0 with port 1 pending
    @(posedge clk);
    #2;
    send(0, 7, 5, 5);
    wait_for("s4_grant", 0, 0);
    link_up = 0;
    send(1, 8, 2, 2);
    wait_for("s4_p0_done", 2, 10);
    repeat (4) @(negedge clk);
    chk("s4_blocked", {grant_valid, 32'(sb.size())}, {1'b0, 32'(2 + HDR)});
    link_up = 1;
    wait_for("s4_drain", 3, 0);
    chk("s4_count", pkt_count, 11);
    // reset on beat 2 of a 5-beat packet
    @(posedge clk);
    #2;
    send(2, 9, 5, 1);
    wait_for("s5_beat0", 1, mk(2, 9, 0));
    @(posedge clk);
    #2;
    rst = 1;
    for (int i = 0; i < N; i++) rd[i] = wr[i];
    drive();
    after_t = 1;
    #1;
    chk("rst_async", {m_valid, m_last, s_ready, grant_valid, grant_port}, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_sb", 64'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    send(0, 10, 1, 1);
    send(2, 11, 2, 2);
    wait_for("s5_drain", 3, 0);
    chk("s5_count", pkt_count, 2);
    // 2-beat packet on port 3
    @(posedge clk);
    #2;
    send(3, 12, 2, 2);
    wait_for("s6_drain", 3, 0);
    chk("s6_count", pkt_count, 3);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
